la_uart_rx: RTL
===============

// Module: la_uart_rx
// PURPOSE
// - Standalone UART receiver: samples uart_rx at 16x oversampling, deframes 8N1 bytes (LSB first), buffers them in a small FIFO.
// - Delivers bytes on a valid/ready stream; drives uart_cts_out for hardware flow control.
// - Sits at the far end of a la_uart uart_tx line: the receive side of the serial link inside syslib.
// PARAMETERS
// - DIVW   16  width of ctrl_div (oversample tick divisor)
// - DEPTH  4   receive FIFO depth in bytes (power of 2, >=2)
// PORTS
// - clk           in   1     core clock; one clock only
// - reset         in   1     reset is synchronous and active-high
// - ctrl_div      in   DIVW  oversample tick every ctrl_div+1 clk; 16 ticks per bit
// - ctrl_podd     in   1     parity select, 1=odd 0=even (used only with LA_UART_RX_PARITY_EN)
// - ctrl_clr      in   1     one-cycle pulse, clears sticky error flags
// - uart_rx       in   1     serial data from io, idle high, asynchronous
// - uart_cts_out  out  1     1 = receiver can accept more bytes
// - rx_valid      out  1     FIFO head byte valid
// - rx_data       out  8     FIFO head byte
// - rx_ready      in   1     consumer accepts rx_data when rx_valid & rx_ready
// - rx_busy       out  1     1 while a frame is in progress (state != IDLE)
// - err_frame     out  1     sticky: stop bit sampled 0
// - err_overrun   out  1     sticky: byte arrived with FIFO full
// - err_parity    out  1     sticky: parity mismatch (0 without macro)
// - irq           out  1     rx_valid | err_frame | err_overrun | err_parity
// BEHAVIOUR
// - Reset: all outputs 0; synchronizer flops 1; FIFO empty; state IDLE; tick counter 0. uart_cts_out rises 1 clk after reset drops.
// - Reset mid-frame: partial byte discarded, FIFO flushed, flags cleared.
// - Input: 2-flop synchronizer on uart_rx; all decisions use synced value.
// - Tick gen: counter 0..ctrl_div, tick when count==ctrl_div then wrap to 0; ctrl_div=0 -> tick every clk. Counter restarts at 0 on start-edge detect.
// - Sample counter s (4 bit) increments per tick; bit sampled at s==7, bit ends at s==15.
// - FSM: IDLE -> START on synced rx==0.
//   START: at s==7 rx==1 -> IDLE (glitch, no flags); else at s==15 -> DATA.
//   DATA: shift in 8 bits LSB first at s==7; after 8th bit end -> PARITY (macro) or STOP.
//   PARITY: sample at s==7, compare; end -> STOP.
//   STOP: at s==7: rx==0 -> err_frame set, byte dropped; rx==1 -> push byte (unless parity error: err_parity set, byte dropped). Go IDLE same cycle (half-bit early, for resync).
// - FIFO push accepted if not full, or if full with pop in same clk; otherwise byte dropped, err_overrun set.
// - rx_data/rx_valid registered from FIFO head; byte visible 1 clk after stop mid-sample. Pop on rx_valid&rx_ready; rx_data stable while rx_valid&!rx_ready.
// - uart_cts_out registered: 1 when FIFO count <= DEPTH-2, else 0.
// - Error flags: set wins over simultaneous ctrl_clr; cleared only by ctrl_clr or reset.
// - ctrl_div changes mid-frame: undefined timing, no lockup; next IDLE resyncs.
// CONFIGURATION
// - LA_UART_RX_PARITY_EN defined: frame = start, 8 data, parity, stop; parity per ctrl_podd; err_parity live.
// - Not defined: 8N1 only, PARITY state absent, ctrl_podd ignored, err_parity tied 0.
// TESTING (ctrl_div=3 -> 4 clk/tick, 64 clk/bit)
// - Send 0xA5 8N1 -> rx_valid=1, rx_data=0xA5 within 1 clk after stop-bit mid sample (~608 clk after start edge); no flags.
// - rx low for 8 clk then high -> no rx_valid, rx_busy returns 0, no flags.
// - Send 0x3C with stop bit 0 -> err_frame=1, irq=1, rx_valid stays 0; ctrl_clr pulse -> err_frame=0.
// - DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05 -> uart_cts_out=0 after 3rd byte, err_overrun=1 on 5th, drain gives 0x01..0x04.
// - Back-to-back 0x55,0xAA with rx_ready=1 -> both received in order, no flags.
// - Macro on, ctrl_podd=1: 0x01 with parity 0 -> accepted; 0x01 with parity 1 -> err_parity=1, byte dropped.

Source files
------------

// File: rtl/la_uart_rx.sv
// la_uart_rx: 16x-oversampling UART receiver with a small receive FIFO,
// a valid/ready output stream, sticky error flags and a CTS output.
// Optional feature macro: LA_UART_RX_PARITY_EN adds a parity bit per frame
// (odd/even chosen by ctrl_podd) and drives err_parity. Without it the
// frame is 8N1 and err_parity is tied low.
module la_uart_rx #(
  parameter int DIVW  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DIVW-1:0] ctrl_div,
  input  logic            ctrl_podd,
  input  logic            ctrl_clr,
  input  logic            uart_rx,
  output logic            uart_cts_out,
  output logic            rx_valid,
  output logic [7:0]      rx_data,
  input  logic            rx_ready,
  output logic            rx_busy,
  output logic            err_frame,
  output logic            err_overrun,
  output logic            err_parity,
  output logic            irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LA_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state;
  logic            rx_s1, rx_s2;
  logic [DIVW-1:0] tick_cnt;
  logic            tick;
  logic [3:0]      s_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bad;
  logic            start_edge;
  logic            stop_mid;
  logic            push_req, frame_set, par_set;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   count, count_next;
  logic            pop, push_ok, overrun_set;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // >= rather than == keeps the divider from running the full counter range
  // when ctrl_div is lowered mid-count.
  assign tick       = (tick_cnt >= ctrl_div);
  assign start_edge = (state == S_IDLE) && !rx_s2;
  assign stop_mid   = (state == S_STOP) && tick && (s_cnt == 4'd7);

  // Oversample tick divider, realigned to the detected start edge.
  always_ff @(posedge clk) begin
    if (reset || start_edge || tick) tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + 1'b1;
  end

  // Frame FSM: bit sampling at s==7, bit boundaries at s==15.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef LA_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE && tick) s_cnt <= s_cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (!rx_s2) begin
            state   <= S_START;
            s_cnt   <= '0;
            bit_cnt <= '0;
`ifdef LA_UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick && s_cnt == 4'd7 && rx_s2) state <= S_IDLE;
          else if (tick && s_cnt == 4'd15)   state <= S_DATA;
        end
        S_DATA: begin
          if (tick && s_cnt == 4'd7) shreg <= {rx_s2, shreg[7:1]};
          if (tick && s_cnt == 4'd15) begin
            if (bit_cnt == 3'd7) begin
`ifdef LA_UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef LA_UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick && s_cnt == 4'd7)  par_bad <= (rx_s2 != (^shreg ^ ctrl_podd));
          if (tick && s_cnt == 4'd15) state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Leave at mid-stop so the next start edge is caught promptly.
          if (tick && s_cnt == 4'd7) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef LA_UART_RX_PARITY_EN
  logic unused_podd;
  assign par_bad     = 1'b0;
  assign unused_podd = ctrl_podd;
`endif

  assign frame_set = stop_mid && !rx_s2;
  assign par_set   = stop_mid &&  rx_s2 &&  par_bad;
  assign push_req  = stop_mid &&  rx_s2 && !par_bad;

  assign pop         = rx_valid && rx_ready;
  assign push_ok     = push_req && ((count != CW'(DEPTH)) || pop);
  assign overrun_set = push_req && !push_ok;

  // Occupancy after this edge; drives the registered head, valid and CTS.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_next = count;
    rd_nxt     = rd_ptr + 1'b1;
    count_next = count + CW'(push_ok) - CW'(pop);
  end

  // FIFO storage: the data array carries no reset, only pointers and count do.
  always_ff @(posedge clk) begin
    // NOTE: the byte array is deliberately left unreset; occupancy is tracked
    // by count, so stale contents are never presented as valid.
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO control, registered head byte and flow-control output.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      uart_cts_out <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_nxt;
      count        <= count_next;
      rx_valid     <= (count_next != '0);
      uart_cts_out <= (count_next <= CW'(DEPTH - 2));
      if (pop) begin
        if (count >= CW'(2))  rx_data <= mem[rd_nxt];
        else if (push_ok)     rx_data <= shreg;
      end else if (count == '0 && push_ok) begin
        rx_data <= shreg;
      end
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
      err_parity  <= 1'b0;
    end else begin
      err_frame   <= frame_set   | (err_frame   & ~ctrl_clr);
      err_overrun <= overrun_set | (err_overrun & ~ctrl_clr);
      err_parity  <= par_set     | (err_parity  & ~ctrl_clr);
    end
  end

  assign rx_busy = (state != S_IDLE);
  assign irq     = rx_valid | err_frame | err_overrun | err_parity;

endmodule
